// File: rtl/exception_reporter.sv
// Captures the first reportable eBPF core exception of a run, freezes the core and holds the cause until the host acks.
// Optional feature: define EXC_DROP_COUNT_EN to count exceptions that arrive after capture (saturating drop_cnt).
module exception_reporter #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ack,
  input  logic             exc_valid,
  input  logic [2:0]       exc_class,
  input  logic [1:0]       exc_desc,
  input  logic [PC_W-1:0]  exc_pc,
  output logic             running,
  output logic             halt,
  output logic             irq,
  output logic             done,
  output logic             fault,
  output logic             bad_code,
  output logic [2:0]       cause_class,
  output logic [1:0]       cause_desc,
  output logic [PC_W-1:0]  cause_pc,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [2:0] CLASS_CTRL = 3'b011;
  localparam logic [1:0] DESC_EXIT  = 2'b11;

  state_t state, next_state;
  logic   reportable, is_exit, is_unassigned, capture, clear, ended;
  logic   running_d, halt_d, irq_d, done_d, fault_d;

  assign reportable    = exc_valid && (exc_class != 3'b000) && (exc_desc != 2'b00);
  assign is_exit       = (exc_class == CLASS_CTRL) && (exc_desc == DESC_EXIT);
  assign is_unassigned = (exc_class == 3'b100) || (exc_class == 3'b111);
  assign capture       = (state == RUN) && reportable;
  assign clear         = (state == IDLE) && start;
  assign ended         = (state == DONE) || (state == FAULT);

  // State register; status outputs are registered from the next state so they
  // change on the same edge as the state itself.
  // NOTE: sequential logic uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
      halt    <= 1'b1;
      irq     <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= next_state;
      running <= running_d;
      halt    <= halt_d;
      irq     <= irq_d;
      done    <= done_d;
      fault   <= fault_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (reportable) next_state = is_exit ? DONE : FAULT;
      DONE,
      FAULT:   if (ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    running_d = (next_state == RUN);
    halt_d    = !running_d;
    done_d    = (next_state == DONE);
    fault_d   = (next_state == FAULT);
    irq_d     = done_d || fault_d;
  end

  // Cause registers: cleared when a run starts, written only on the capturing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_class <= 3'b000;
      cause_desc  <= 2'b00;
      cause_pc    <= '0;
      bad_code    <= 1'b0;
    end else if (clear) begin
      cause_class <= 3'b000;
      cause_desc  <= 2'b00;
      cause_pc    <= '0;
      bad_code    <= 1'b0;
    end else if (capture) begin
      cause_class <= exc_class;
      cause_desc  <= exc_desc;
      cause_pc    <= exc_pc;
      bad_code    <= is_unassigned;
    end
  end

`ifdef EXC_DROP_COUNT_EN
  // Counts late exceptions even on the ack edge; the value is discarded at the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (clear) begin
      drop_cnt <= '0;
    end else if (ended && reportable && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule
